// File: rtl/svm_feature_builder.sv
// svm_feature_builder
// Assembles per-flow packet sizes into fixed-length feature vectors for
// svm_detection. Each packet of a flow contributes one feature. A flow that
// ends early is zero-padded. Packets that arrive after a vector is complete
// are skipped. Completed vectors wait in a small FIFO and are issued one at a
// time as single-cycle data_valid pulses.
//
// Build option: define SVM_FEATURE_SAT_EN to saturate oversize packet sizes
// to the largest feature value. Without it, oversize sizes are truncated to
// their low PARAM_WIDTH bits.
//
// Requires PARAM_COUNT >= 2 and a FIFO_DEPTH that is a power of two >= 2.

`ifndef SVM_PARAM_COUNT
`define SVM_PARAM_COUNT 4
`endif
`ifndef SVM_PARAM_WIDTH
`define SVM_PARAM_WIDTH 8
`endif

module svm_feature_builder #(
  parameter int PARAM_COUNT = `SVM_PARAM_COUNT,
  parameter int PARAM_WIDTH = `SVM_PARAM_WIDTH,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [15:0]                        pkt_size,
  input  logic                               pkt_valid,
  input  logic                               pkt_first,
  input  logic                               pkt_last,
  output logic                               pkt_ready,
  output logic [PARAM_WIDTH*PARAM_COUNT-1:0] x,
  output logic                               data_valid,
  input  logic                               svm_ready,
  output logic [15:0]                        abandoned_count
);

  localparam int VW = PARAM_WIDTH * PARAM_COUNT;
  localparam int IW = (PARAM_COUNT > 2) ? $clog2(PARAM_COUNT) : 1;
  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PARAM_COUNT - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAD     = 2'd2,
    SKIP    = 2'd3
  } state_t;

  // Map a packet size onto a feature value.
  function automatic logic [PARAM_WIDTH-1:0] to_feature(input logic [15:0] size);
`ifdef SVM_FEATURE_SAT_EN
    logic [31:0] feat_max;
    feat_max = (PARAM_WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << PARAM_WIDTH) - 32'd1);
    if ((PARAM_WIDTH < 16) && ({16'd0, size} > feat_max)) begin
      return '1;
    end else begin
      return PARAM_WIDTH'(size);
    end
`else
    return PARAM_WIDTH'(size);
`endif
  endfunction

  state_t              state_r;
  logic [IW-1:0]       idx_r;
  logic [VW-1:0]       asm_r;
  logic [15:0]         abandoned_r;
  logic [VW-1:0]       mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [LW-1:0]       level_r;
  logic [VW-1:0]       x_r;
  logic                dv_r;

  logic                fifo_full_s;
  logic                accept_s;
  logic                push_s;
  logic                pop_s;
  logic [PARAM_WIDTH-1:0] feat_s;
  logic [VW-1:0]       push_vec_s;

  assign fifo_full_s     = (level_r == FULL_LVL);
  assign pkt_ready       = !fifo_full_s && (state_r != PAD);
  assign accept_s        = pkt_valid && pkt_ready;
  assign pop_s           = (level_r != {LW{1'b0}}) && svm_ready && !dv_r;
  assign x               = x_r;
  assign data_valid      = dv_r;
  assign abandoned_count = abandoned_r;

  // Decide whether the current slot completes a vector and form that vector.
  always_comb begin
    feat_s     = to_feature(pkt_size);
    push_s     = 1'b0;
    push_vec_s = asm_r;
    case (state_r)
      COLLECT: begin
        push_s = accept_s && !pkt_first && (idx_r == LAST_IDX);
        push_vec_s[int'(idx_r)*PARAM_WIDTH +: PARAM_WIDTH] = feat_s;
      end
      PAD: begin
        push_s = !fifo_full_s && (idx_r == LAST_IDX);
        push_vec_s[int'(idx_r)*PARAM_WIDTH +: PARAM_WIDTH] = {PARAM_WIDTH{1'b0}};
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // Flow-tracking FSM: assembles features, pads short flows, skips tails.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= {IW{1'b0}};
      asm_r       <= {VW{1'b0}};
      abandoned_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && pkt_first) begin
            asm_r[PARAM_WIDTH-1:0] <= feat_s;
            idx_r   <= ONE_IDX;
            state_r <= pkt_last ? PAD : COLLECT;
          end
        end
        COLLECT: begin
          if (accept_s) begin
            if (pkt_first) begin
              // A new flow overtakes an unfinished one.
              if (abandoned_r != 16'hFFFF) begin
                abandoned_r <= abandoned_r + 16'd1;
              end
              asm_r[PARAM_WIDTH-1:0] <= feat_s;
              idx_r   <= ONE_IDX;
              state_r <= pkt_last ? PAD : COLLECT;
            end else begin
              asm_r <= push_vec_s;
              if (idx_r == LAST_IDX) begin
                idx_r   <= {IW{1'b0}};
                state_r <= pkt_last ? IDLE : SKIP;
              end else begin
                idx_r   <= idx_r + ONE_IDX;
                state_r <= pkt_last ? PAD : COLLECT;
              end
            end
          end
        end
        SKIP: begin
          if (accept_s) begin
            if (pkt_first) begin
              asm_r[PARAM_WIDTH-1:0] <= feat_s;
              idx_r   <= ONE_IDX;
              state_r <= pkt_last ? PAD : COLLECT;
            end else if (pkt_last) begin
              state_r <= IDLE;
            end
          end
        end
        PAD: begin
          // Padding stalls while the FIFO is full so the final push never overflows.
          if (!fifo_full_s) begin
            asm_r <= push_vec_s;
            if (idx_r == LAST_IDX) begin
              idx_r   <= {IW{1'b0}};
              state_r <= IDLE;
            end else begin
              idx_r <= idx_r + ONE_IDX;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= {IW{1'b0}};
        end
      endcase
    end
  end

  // FIFO storage write port; contents are don't-care while the level is zero.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_vec_s;
    end
  end

  // FIFO pointers, occupancy and the single-cycle issue of the head vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      x_r      <= {VW{1'b0}};
      dv_r     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        x_r      <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      dv_r <= pop_s;
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + {{(LW-1){1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{(LW-1){1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

endmodule
